// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the registered output bundle and a counter-width helper.
package vga_timing_pkg;

    localparam int unsigned COORD_W      = 10;

    localparam int unsigned CLK_DIV_DEF  = 2;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned H_SYNC_W_DEF = 96;
    localparam int unsigned H_BACK_DEF   = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam int unsigned V_SYNC_W_DEF = 2;
    localparam int unsigned V_BACK_DEF   = 33;

    localparam int unsigned H_TOTAL_DEF      = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_W_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF      = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_W_DEF + V_BACK_DEF;
    localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FRONT_DEF;
    localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_W_DEF;
    localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FRONT_DEF;
    localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_W_DEF;

    typedef struct packed {
        logic               h_sync;
        logic               v_sync;
        logic               pixel_tick;
        logic               video_active;
        logic [COORD_W-1:0] pixel_x;
        logic [COORD_W-1:0] pixel_y;
        logic               frame_start;
    } vga_out_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus next-value active/sync decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL_DEF,
    parameter int unsigned ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned SYNC_END   = H_SYNC_END_DEF,
    parameter int unsigned W          = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count_next,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int unsigned WX = W + 1;
    localparam logic [W-1:0]  LAST    = W'(TOTAL - 1);
    localparam logic [WX-1:0] ACT_X   = WX'(ACTIVE);
    localparam logic [WX-1:0] SS_X    = WX'(SYNC_START);
    localparam logic [WX-1:0] SE_X    = WX'(SYNC_END);

    logic [W-1:0]  count_q;
    logic [W-1:0]  count_d;
    logic [WX-1:0] count_x;
    logic          at_last;

    // Decode works on the next value so registered outputs line up with the counter.
    always_comb begin
        at_last = (count_q == LAST);
        wrap    = enable && at_last;
        count_d = count_q;
        if (reset) begin
            count_d = LAST;
        end else if (enable) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
        count_x = {1'b0, count_d};
        active  = (count_x < ACT_X);
        sync    = (count_x >= SS_X) && (count_x < SE_X);
    end

    assign count_next = count_d;

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel divider, H/V axis counters, registered outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT  = H_FRONT_DEF,
    parameter int unsigned H_SYNC_W = H_SYNC_W_DEF,
    parameter int unsigned H_BACK   = H_BACK_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT  = V_FRONT_DEF,
    parameter int unsigned V_SYNC_W = V_SYNC_W_DEF,
    parameter int unsigned V_BACK   = V_BACK_DEF,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    output logic               H_SYNC,
    output logic               V_SYNC,
    output logic               pixel_tick,
    output logic               video_active,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC_W + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC_W + V_BACK;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);
    localparam int unsigned DW      = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          step;
    logic          advance;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;
    vga_out_t      out_q, out_d;

    always_comb begin
        step    = (div_q == DIV_LAST);
        advance = step && !reset;
        div_d   = (reset || step) ? '0 : div_q + 1'b1;
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (HS_BEG),
        .SYNC_END   (HS_BEG + H_SYNC_W),
        .W          (HW)
    ) u_h_axis (
        .clk        (CLOCK_50),
        .reset      (reset),
        .enable     (advance),
        .count_next (h_next),
        .wrap       (h_wrap),
        .active     (h_active),
        .sync       (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (VS_BEG),
        .SYNC_END   (VS_BEG + V_SYNC_W),
        .W          (VW)
    ) u_v_axis (
        .clk        (CLOCK_50),
        .reset      (reset),
        .enable     (h_wrap),
        .count_next (v_next),
        .wrap       (v_wrap),
        .active     (v_active),
        .sync       (v_sync)
    );

    always_comb begin
        out_d.h_sync       = ~SYNC_POL;
        out_d.v_sync       = ~SYNC_POL;
        out_d.pixel_tick   = 1'b0;
        out_d.video_active = 1'b0;
        out_d.pixel_x      = '0;
        out_d.pixel_y      = '0;
        out_d.frame_start  = 1'b0;
        if (!reset) begin
            out_d.h_sync       = h_sync ? SYNC_POL : ~SYNC_POL;
            out_d.v_sync       = v_sync ? SYNC_POL : ~SYNC_POL;
            out_d.pixel_tick   = advance;
            out_d.video_active = h_active && v_active;
            if (h_active && v_active) begin
                out_d.pixel_x = COORD_W'(h_next);
                out_d.pixel_y = COORD_W'(v_next);
            end
            // Both axes wrapping on one step is exactly the move into (0,0).
            out_d.frame_start  = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        div_q <= div_d;
        out_q <= out_d;
    end

    assign H_SYNC       = out_q.h_sync;
    assign V_SYNC       = out_q.v_sync;
    assign pixel_tick   = out_q.pixel_tick;
    assign video_active = out_q.video_active;
    assign pixel_x      = out_q.pixel_x;
    assign pixel_y      = out_q.pixel_y;
    assign frame_start  = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 instance plus a tiny 8x6 raster instance.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic               hs_a, vs_a, tick_a, act_a, fs_a;
    logic [COORD_W-1:0] x_a, y_a;
    logic               hs_b, vs_b, tick_b, act_b, fs_b;
    logic [COORD_W-1:0] x_b, y_b;

    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int unsigned at;
        logic [24:0] exp;
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    localparam int unsigned T0 = 7;   // default DUT: first step after release at cycle 5
    localparam int unsigned S0 = 6;   // tiny DUT (CLK_DIV=1): first step after release

    vga_timing_gen u_dut_a (
        .CLOCK_50     (clk),
        .reset        (rst_a),
        .H_SYNC       (hs_a),
        .V_SYNC       (vs_a),
        .pixel_tick   (tick_a),
        .video_active (act_a),
        .pixel_x      (x_a),
        .pixel_y      (y_a),
        .frame_start  (fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV  (1),
        .H_ACTIVE (4),
        .H_FRONT  (1),
        .H_SYNC_W (2),
        .H_BACK   (1),
        .V_ACTIVE (3),
        .V_FRONT  (1),
        .V_SYNC_W (1),
        .V_BACK   (1),
        .SYNC_POL (1'b0)
    ) u_dut_b (
        .CLOCK_50     (clk),
        .reset        (rst_b),
        .H_SYNC       (hs_b),
        .V_SYNC       (vs_b),
        .pixel_tick   (tick_b),
        .video_active (act_b),
        .pixel_x      (x_b),
        .pixel_y      (y_b),
        .frame_start  (fs_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [24:0] pk(input bit t, input bit f, input bit a,
                                       input int x, input int y, input bit h, input bit v);
        return {t, f, a, 10'(x), 10'(y), h, v};
    endfunction

    function automatic string fmt(input logic [24:0] s);
        return $sformatf("tick=%b fs=%b act=%b x=%0d y=%0d hs=%b vs=%b",
                         s[24], s[23], s[22], s[21:12], s[11:2], s[1], s[0]);
    endfunction

    task automatic push_a(input int unsigned at, input logic [24:0] e, input string n);
        q_a.push_back('{at: at, exp: e, name: n});
    endtask

    task automatic push_b(input int unsigned at, input logic [24:0] e, input string n);
        q_b.push_back('{at: at, exp: e, name: n});
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: compares DUT outputs against queued expectations, away from the active edge.
    initial begin
        exp_t        e;
        logic [24:0] obs;
        forever begin
            @(negedge clk);
            obs = {tick_a, fs_a, act_a, x_a, y_a, hs_a, vs_a};
            while (q_a.size() > 0 && q_a[0].at <= cyc) begin
                e = q_a.pop_front();
                total++;
                if (e.at != cyc || obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: got %s, want %s", e.name, cyc, fmt(obs), fmt(e.exp));
                end
            end
            obs = {tick_b, fs_b, act_b, x_b, y_b, hs_b, vs_b};
            while (q_b.size() > 0 && q_b[0].at <= cyc) begin
                e = q_b.pop_front();
                total++;
                if (e.at != cyc || obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0d: got %s, want %s", e.name, cyc, fmt(obs), fmt(e.exp));
                end
            end
        end
    end

    initial begin
        logic [24:0] rst_val;
        rst_val = pk(0, 0, 0, 0, 0, 1, 1);

        // Reset phase and first step out of reset.
        push_a(3, rst_val, "a_reset");
        push_a(6, rst_val, "a_pre_step");
        push_b(3, rst_val, "b_reset");
        push_b(5, rst_val, "b_reset_end");

        // Default raster, line 0 and start of line 1.
        push_a(T0,        pk(1, 1, 1,   0, 0, 1, 1), "a_first_pixel");
        push_a(T0 + 1,    pk(0, 0, 1,   0, 0, 1, 1), "a_tick_low");
        push_a(T0 + 2,    pk(1, 0, 1,   1, 0, 1, 1), "a_x1");
        push_a(T0 + 1278, pk(1, 0, 1, 639, 0, 1, 1), "a_x639");
        push_a(T0 + 1279, pk(0, 0, 1, 639, 0, 1, 1), "a_x639_hold");
        push_a(T0 + 1280, pk(1, 0, 0,   0, 0, 1, 1), "a_x640");
        push_a(T0 + 1311, pk(0, 0, 0,   0, 0, 1, 1), "a_hs_pre");
        push_a(T0 + 1312, pk(1, 0, 0,   0, 0, 0, 1), "a_hs_start");
        push_a(T0 + 1503, pk(0, 0, 0,   0, 0, 0, 1), "a_hs_last");
        push_a(T0 + 1504, pk(1, 0, 0,   0, 0, 1, 1), "a_hs_end");
        push_a(T0 + 1598, pk(1, 0, 0,   0, 0, 1, 1), "a_h799");
        push_a(T0 + 1600, pk(1, 0, 1,   0, 1, 1, 1), "a_line1");
        push_a(T0 + 1602, pk(1, 0, 1,   1, 1, 1, 1), "a_line1_x1");

        // Tiny raster: 8-cycle line, 48-cycle frame.
        push_b(S0,      pk(1, 1, 1, 0, 0, 1, 1), "b_first_pixel");
        push_b(S0 + 3,  pk(1, 0, 1, 3, 0, 1, 1), "b_x3");
        push_b(S0 + 4,  pk(1, 0, 0, 0, 0, 1, 1), "b_x4_blank");
        push_b(S0 + 5,  pk(1, 0, 0, 0, 0, 0, 1), "b_hs_h5");
        push_b(S0 + 6,  pk(1, 0, 0, 0, 0, 0, 1), "b_hs_h6");
        push_b(S0 + 7,  pk(1, 0, 0, 0, 0, 1, 1), "b_hs_h7");
        push_b(S0 + 8,  pk(1, 0, 1, 0, 1, 1, 1), "b_line1");
        push_b(S0 + 18, pk(1, 0, 1, 2, 2, 1, 1), "b_y2");
        push_b(S0 + 24, pk(1, 0, 0, 0, 0, 1, 1), "b_y3_blank");
        push_b(S0 + 29, pk(1, 0, 0, 0, 0, 0, 1), "b_v3_hs");
        push_b(S0 + 32, pk(1, 0, 0, 0, 0, 1, 0), "b_vs_start");
        push_b(S0 + 37, pk(1, 0, 0, 0, 0, 0, 0), "b_vs_hs");
        push_b(S0 + 39, pk(1, 0, 0, 0, 0, 1, 0), "b_vs_last");
        push_b(S0 + 40, pk(1, 0, 0, 0, 0, 1, 1), "b_vs_end");
        push_b(S0 + 47, pk(1, 0, 0, 0, 0, 1, 1), "b_frame_last");
        push_b(S0 + 48, pk(1, 1, 1, 0, 0, 1, 1), "b_frame2");
        push_b(S0 + 49, pk(1, 0, 1, 1, 0, 1, 1), "b_frame2_x1");
        push_b(S0 + 96, pk(1, 1, 1, 0, 0, 1, 1), "b_frame3");

        wait_cyc(5);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Mid-line reset at h=700 on line 1, held across a step edge.
        push_a(T0 + 3000, pk(1, 0, 0, 0, 0, 0, 1), "a_h700_hs");
        push_a(T0 + 3001, rst_val, "a_midreset");
        push_a(T0 + 3002, rst_val, "a_reset_over_step");
        push_a(T0 + 3003, rst_val, "a_post_release");
        push_a(T0 + 3004, pk(1, 1, 1, 0, 0, 1, 1), "a_restart");
        push_a(T0 + 3005, pk(0, 0, 1, 0, 0, 1, 1), "a_restart_hold");
        push_a(T0 + 3006, pk(1, 0, 1, 1, 0, 1, 1), "a_restart_x1");

        wait_cyc(T0 + 3000);
        rst_a = 1'b1;
        wait_cyc(T0 + 3002);
        rst_a = 1'b0;

        while ((q_a.size() > 0 || q_b.size() > 0) && cyc < 5000) @(negedge clk);
        foreach (q_a[i]) begin
            total++;
            bad++;
            $display("FAIL %s: never checked, want %s", q_a[i].name, fmt(q_a[i].exp));
        end
        foreach (q_b[i]) begin
            total++;
            bad++;
            $display("FAIL %s: never checked, want %s", q_b[i].name, fmt(q_b[i].exp));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
